// File: rtl/motor_cmd_scheduler.sv
// Motor command scheduler: arbitrates estop/manual/auto sources, paces JSON motor
// frames through json_uart_sender, re-sends on heartbeat and recovers from a stalled sender.
module motor_cmd_scheduler #(
   parameter int unsigned HEARTBEAT_CYCLES = 50000000,
   parameter int unsigned MIN_GAP_CYCLES   = 1000,
   parameter int unsigned FRAME_TIMEOUT    = 100000,
   parameter int unsigned CNT_W            = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             estop,
   input  logic             manual_valid,
   input  logic [4:0]       manual_cmd,
   input  logic             auto_valid,
   input  logic [4:0]       auto_cmd,
   input  logic             uart_valid,
   input  logic             uart_ready,
   output logic [4:0]       motor_cmd,
   output logic             trigger,
   output logic             busy,
   output logic [1:0]       source,
   output logic [CNT_W-1:0] frames_sent,
   output logic [7:0]       last_bytes,
   output logic             timeout_err
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_TRIG       = 3'd1;
   localparam logic [2:0] S_WAIT_START = 3'd2;
   localparam logic [2:0] S_WAIT_DONE  = 3'd3;
   localparam logic [2:0] S_GAP        = 3'd4;

   localparam logic [4:0] CMD_STOP = 5'b00001;

   localparam logic [1:0] SRC_NONE   = 2'd0;
   localparam logic [1:0] SRC_AUTO   = 2'd1;
   localparam logic [1:0] SRC_MANUAL = 2'd2;
   localparam logic [1:0] SRC_ESTOP  = 2'd3;

   localparam int unsigned HB_W  = $clog2(HEARTBEAT_CYCLES + 1);
   localparam int unsigned GAP_W = $clog2(MIN_GAP_CYCLES + 1);
   localparam int unsigned TO_W  = $clog2(FRAME_TIMEOUT + 1);

   localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HEARTBEAT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_GAP_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(FRAME_TIMEOUT - 1);

   logic [2:0]       state;
   logic             first_frame;
   logic             hb_due;
   logic [4:0]       last_sent_cmd;
   logic [HB_W-1:0]  hb_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic [TO_W-1:0]  to_cnt;
   logic [7:0]       byte_cnt;

   logic [4:0]       sel_cmd;
   logic [1:0]       sel_src;
   logic             send;

   // With no active source the previously latched command and source are held.
   always_comb begin
      sel_cmd = motor_cmd;
      sel_src = source;
      if (estop) begin
         sel_cmd = CMD_STOP;
         sel_src = SRC_ESTOP;
      end else if (manual_valid) begin
         sel_cmd = $onehot(manual_cmd) ? manual_cmd : CMD_STOP;
         sel_src = SRC_MANUAL;
      end else if (auto_valid) begin
         sel_cmd = $onehot(auto_cmd) ? auto_cmd : CMD_STOP;
         sel_src = SRC_AUTO;
      end
      send = first_frame || (sel_cmd != last_sent_cmd) || hb_due;
   end

   always_comb begin
      trigger = (state == S_TRIG);
      busy    = (state == S_TRIG) || (state == S_WAIT_START) || (state == S_WAIT_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= S_IDLE;
         motor_cmd     <= CMD_STOP;
         source        <= SRC_NONE;
         frames_sent   <= '0;
         last_bytes    <= '0;
         timeout_err   <= 1'b0;
         first_frame   <= 1'b1;
         hb_due        <= 1'b0;
         last_sent_cmd <= CMD_STOP;
         hb_cnt        <= '0;
         gap_cnt       <= '0;
         to_cnt        <= '0;
         byte_cnt      <= '0;
      end else begin
         if ((state == S_IDLE) || (state == S_GAP)) begin
            if (hb_cnt == HB_LAST) begin
               hb_due <= 1'b1;
            end else begin
               hb_cnt <= hb_cnt + HB_W'(1);
            end
         end

         case (state)
            S_IDLE: begin
               if (send) begin
                  motor_cmd <= sel_cmd;
                  source    <= sel_src;
                  to_cnt    <= '0;
                  byte_cnt  <= '0;
                  state     <= S_TRIG;
               end
            end

            S_TRIG: begin
               state <= S_WAIT_START;
            end

            S_WAIT_START: begin
               if (uart_valid) begin
                  to_cnt <= to_cnt + TO_W'(1);
                  state  <= S_WAIT_DONE;
               end else if (to_cnt == TO_LAST) begin
                  timeout_err <= 1'b1;
                  gap_cnt     <= '0;
                  state       <= S_GAP;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end

            // Frame end is tested before the timeout so it wins when both coincide.
            S_WAIT_DONE: begin
               if (!uart_valid) begin
                  frames_sent   <= frames_sent + CNT_W'(1);
                  last_bytes    <= byte_cnt;
                  last_sent_cmd <= motor_cmd;
                  first_frame   <= 1'b0;
                  hb_due        <= 1'b0;
                  hb_cnt        <= '0;
                  gap_cnt       <= '0;
                  state         <= S_GAP;
               end else if (to_cnt == TO_LAST) begin
                  timeout_err <= 1'b1;
                  gap_cnt     <= '0;
                  state       <= S_GAP;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
                  if (uart_ready && (byte_cnt != 8'hFF)) begin
                     byte_cnt <= byte_cnt + 8'd1;
                  end
               end
            end

            S_GAP: begin
               if (estop && (last_sent_cmd != CMD_STOP)) begin
                  state <= S_IDLE;
               end else if (gap_cnt == GAP_LAST) begin
                  state <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Directed bench for motor_cmd_scheduler with a behavioural json_uart_sender model.
module tb_motor_cmd_scheduler;

   localparam logic [4:0] STOP  = 5'b00001;
   localparam logic [4:0] FWD   = 5'b00010;
   localparam logic [4:0] RIGHT = 5'b00100;
   localparam logic [4:0] LEFT  = 5'b01000;
   localparam logic [4:0] BACK  = 5'b10000;
   localparam int unsigned FRAME_BYTES = 29;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        estop = 1'b0;
   logic        manual_valid = 1'b0;
   logic [4:0]  manual_cmd = 5'b0;
   logic        auto_valid = 1'b0;
   logic [4:0]  auto_cmd = 5'b0;
   logic        uart_valid = 1'b0;
   logic        uart_ready = 1'b0;
   logic [4:0]  motor_cmd;
   logic        trigger;
   logic        busy;
   logic [1:0]  source;
   logic [15:0] frames_sent;
   logic [7:0]  last_bytes;
   logic        timeout_err;

   motor_cmd_scheduler #(
      .HEARTBEAT_CYCLES(200),
      .MIN_GAP_CYCLES(4),
      .FRAME_TIMEOUT(100),
      .CNT_W(16)
   ) dut (
      .clk(clk), .rst(rst), .estop(estop),
      .manual_valid(manual_valid), .manual_cmd(manual_cmd),
      .auto_valid(auto_valid), .auto_cmd(auto_cmd),
      .uart_valid(uart_valid), .uart_ready(uart_ready),
      .motor_cmd(motor_cmd), .trigger(trigger), .busy(busy), .source(source),
      .frames_sent(frames_sent), .last_bytes(last_bytes), .timeout_err(timeout_err)
   );

   initial forever #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc = 0;
   int unsigned trig_count = 0;
   int unsigned trig_cyc = 0;
   int unsigned end_cyc = 0;
   logic [4:0]  trig_cmd = 5'b0;
   logic [1:0]  trig_src = 2'b0;
   bit          sender_dead = 1'b0;
   bit          active = 1'b0;
   bit          skip = 1'b0;
   int unsigned hs = 0;

   // Monitor and sender model, both on the falling edge. The sender raises valid the
   // cycle after trigger, keeps ready low for two cycles, then toggles ready until
   // FRAME_BYTES handshakes have happened; end_cyc marks the cycle valid drops.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (trigger === 1'b1) begin
            trig_count++;
            trig_cyc = cyc;
            trig_cmd = motor_cmd;
            trig_src = source;
         end
         if (!rst) begin
            uart_valid = 1'b0;
            uart_ready = 1'b0;
            active = 1'b0;
         end else if (trigger === 1'b1) begin
            if (!sender_dead) begin
               uart_valid = 1'b1;
               uart_ready = 1'b0;
               active = 1'b1;
               skip = 1'b1;
               hs = 0;
            end
         end else if (active) begin
            if (skip) begin
               skip = 1'b0;
            end else begin
               if (uart_ready) hs++;
               if (hs == FRAME_BYTES) begin
                  uart_valid = 1'b0;
                  uart_ready = 1'b0;
                  active = 1'b0;
                  end_cyc = cyc;
               end else begin
                  uart_ready = ~uart_ready;
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_trig(input int unsigned prev, input int unsigned budget, output bit ok);
      ok = 1'b0;
      for (int unsigned i = 0; i < budget; i++) begin
         tick(1);
         if (trig_count != prev) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_not_busy(input int unsigned budget, output bit ok);
      ok = 1'b0;
      for (int unsigned i = 0; i < budget; i++) begin
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic wait_end(input int unsigned prev_end, input int unsigned budget, output bit ok);
      ok = 1'b0;
      for (int unsigned i = 0; i < budget; i++) begin
         tick(1);
         if (end_cyc != prev_end) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   typedef struct {
      logic       estop;
      logic       man_v;
      logic [4:0] man_c;
      logic       auto_v;
      logic [4:0] auto_c;
      logic       exp_send;
      logic [4:0] exp_cmd;
      logic [1:0] exp_src;
   } vec_t;

   vec_t vecs[14];

   initial begin
      bit ok;
      int unsigned prev;
      int unsigned exp_frames;
      int unsigned n0;
      int unsigned e0;

      vecs[0]  = '{1'b0, 1'b0, 5'b0,    1'b1, FWD,      1'b1, FWD,   2'd1};
      vecs[1]  = '{1'b0, 1'b0, 5'b0,    1'b1, FWD,      1'b0, FWD,   2'd1};
      vecs[2]  = '{1'b0, 1'b0, 5'b0,    1'b1, 5'b00110, 1'b1, STOP,  2'd1};
      vecs[3]  = '{1'b0, 1'b0, 5'b0,    1'b1, FWD,      1'b1, FWD,   2'd1};
      vecs[4]  = '{1'b0, 1'b0, 5'b0,    1'b1, 5'b00000, 1'b1, STOP,  2'd1};
      vecs[5]  = '{1'b0, 1'b1, LEFT,    1'b1, FWD,      1'b1, LEFT,  2'd2};
      vecs[6]  = '{1'b0, 1'b1, BACK,    1'b1, FWD,      1'b1, BACK,  2'd2};
      vecs[7]  = '{1'b0, 1'b1, 5'b11000, 1'b1, FWD,     1'b1, STOP,  2'd2};
      vecs[8]  = '{1'b0, 1'b0, LEFT,    1'b1, RIGHT,    1'b1, RIGHT, 2'd1};
      vecs[9]  = '{1'b1, 1'b1, LEFT,    1'b1, FWD,      1'b1, STOP,  2'd3};
      vecs[10] = '{1'b0, 1'b0, LEFT,    1'b0, FWD,      1'b0, STOP,  2'd3};
      vecs[11] = '{1'b0, 1'b0, LEFT,    1'b1, STOP,     1'b0, STOP,  2'd3};
      vecs[12] = '{1'b0, 1'b0, LEFT,    1'b1, RIGHT,    1'b1, RIGHT, 2'd1};
      vecs[13] = '{1'b0, 1'b0, LEFT,    1'b0, RIGHT,    1'b0, RIGHT, 2'd1};

      // Reset values
      tick(3);
      check("rst_motor_cmd", motor_cmd, STOP);
      check("rst_source", source, 0);
      check("rst_trigger", trigger, 0);
      check("rst_busy", busy, 0);
      check("rst_frames", frames_sent, 0);
      check("rst_last_bytes", last_bytes, 0);
      check("rst_timeout_err", timeout_err, 0);

      // First frame after reset: STOP with source none
      rst = 1'b1;
      exp_frames = 0;
      wait_trig(0, 10, ok);
      check("first_trig_seen", ok, 1);
      check("first_trig_cmd", trig_cmd, STOP);
      check("first_trig_src", trig_src, 0);
      check("first_busy", busy, 1);
      wait_not_busy(150, ok);
      check("first_done", ok, 1);
      exp_frames++;
      tick(6);
      check("first_frames", frames_sent, exp_frames);
      check("first_last_bytes", last_bytes, FRAME_BYTES);
      check("first_source", source, 0);
      check("first_one_trig", trig_count, 1);

      // Selection table
      for (int unsigned r = 0; r < 14; r++) begin
         estop = vecs[r].estop;
         manual_valid = vecs[r].man_v;
         manual_cmd = vecs[r].man_c;
         auto_valid = vecs[r].auto_v;
         auto_cmd = vecs[r].auto_c;
         prev = trig_count;
         wait_trig(prev, 10, ok);
         if (vecs[r].exp_send) begin
            check($sformatf("row%0d_send", r), ok, 1);
            check($sformatf("row%0d_cmd", r), trig_cmd, vecs[r].exp_cmd);
            check($sformatf("row%0d_src", r), trig_src, vecs[r].exp_src);
            wait_not_busy(150, ok);
            check($sformatf("row%0d_done", r), ok, 1);
            exp_frames++;
            tick(6);
            check($sformatf("row%0d_one_trig", r), trig_count - prev, 1);
            check($sformatf("row%0d_last_bytes", r), last_bytes, FRAME_BYTES);
         end else begin
            check($sformatf("row%0d_nosend", r), ok, 0);
         end
         check($sformatf("row%0d_motor_cmd", r), motor_cmd, vecs[r].exp_cmd);
         check($sformatf("row%0d_source", r), source, vecs[r].exp_src);
         check($sformatf("row%0d_frames", r), frames_sent, exp_frames);
      end

      // Heartbeat: same command re-sent; latched 201 edges after the frame-end edge
      e0 = end_cyc;
      prev = trig_count;
      wait_trig(prev, 300, ok);
      check("hb_seen", ok, 1);
      check("hb_cycle", trig_cyc, e0 + 202);
      check("hb_cmd", trig_cmd, RIGHT);
      check("hb_src", trig_src, 1);
      wait_not_busy(150, ok);
      check("hb_done", ok, 1);
      exp_frames++;
      tick(6);
      check("hb_frames", frames_sent, exp_frames);
      check("hb_one_trig", trig_count - prev, 1);

      // Manual request mid-frame is held off until frame end plus the gap
      auto_valid = 1'b1;
      auto_cmd = FWD;
      prev = trig_count;
      wait_trig(prev, 10, ok);
      check("mid_fwd_seen", ok, 1);
      check("mid_fwd_cmd", trig_cmd, FWD);
      tick(10);
      manual_valid = 1'b1;
      manual_cmd = LEFT;
      e0 = end_cyc;
      wait_end(e0, 150, ok);
      check("mid_end_seen", ok, 1);
      check("mid_hold_cmd", motor_cmd, FWD);
      check("mid_hold_src", source, 1);
      prev = trig_count;
      wait_trig(prev, 20, ok);
      exp_frames++;
      check("mid_left_seen", ok, 1);
      check("mid_left_cycle", trig_cyc, end_cyc + 6);
      check("mid_left_cmd", trig_cmd, LEFT);
      check("mid_left_src", trig_src, 2);
      check("mid_frames", frames_sent, exp_frames);

      // Estop during the LEFT frame: frame completes, STOP skips the gap
      tick(10);
      estop = 1'b1;
      e0 = end_cyc;
      wait_end(e0, 150, ok);
      check("estop_end_seen", ok, 1);
      check("estop_hold_cmd", motor_cmd, LEFT);
      check("estop_busy", busy, 1);
      prev = trig_count;
      wait_trig(prev, 20, ok);
      exp_frames++;
      check("estop_seen", ok, 1);
      check("estop_cycle", trig_cyc, end_cyc + 3);
      check("estop_cmd", trig_cmd, STOP);
      check("estop_src", trig_src, 3);
      check("estop_frames", frames_sent, exp_frames);
      wait_not_busy(150, ok);
      check("estop_done", ok, 1);
      exp_frames++;
      tick(6);
      check("estop_last_bytes", last_bytes, FRAME_BYTES);

      // Dead sender: abort 101 edges after trigger, retry after the gap
      sender_dead = 1'b1;
      estop = 1'b0;
      manual_valid = 1'b0;
      prev = trig_count;
      wait_trig(prev, 10, ok);
      check("to_trig_seen", ok, 1);
      check("to_trig_cmd", trig_cmd, FWD);
      n0 = trig_cyc;
      tick(n0 + 100 - cyc);
      check("to_err_before", timeout_err, 0);
      check("to_busy_before", busy, 1);
      tick(1);
      check("to_err_set", timeout_err, 1);
      check("to_busy_after", busy, 0);
      check("to_frames_same", frames_sent, exp_frames);
      sender_dead = 1'b0;
      prev = trig_count;
      wait_trig(prev, 20, ok);
      check("to_retry_seen", ok, 1);
      check("to_retry_cycle", trig_cyc, n0 + 106);
      check("to_retry_cmd", trig_cmd, FWD);
      check("to_retry_src", trig_src, 1);
      wait_not_busy(150, ok);
      check("to_retry_done", ok, 1);
      exp_frames++;
      tick(6);
      check("to_retry_frames", frames_sent, exp_frames);
      check("to_err_sticky", timeout_err, 1);

      // Reset mid-frame, then a fresh STOP frame with source none
      auto_cmd = RIGHT;
      prev = trig_count;
      wait_trig(prev, 10, ok);
      check("mrst_trig_seen", ok, 1);
      tick(10);
      rst = 1'b0;
      auto_valid = 1'b0;
      tick(1);
      check("mrst_cmd", motor_cmd, STOP);
      check("mrst_src", source, 0);
      check("mrst_busy", busy, 0);
      check("mrst_frames", frames_sent, 0);
      check("mrst_err", timeout_err, 0);
      check("mrst_last_bytes", last_bytes, 0);
      rst = 1'b1;
      prev = trig_count;
      wait_trig(prev, 10, ok);
      check("mrst_first_seen", ok, 1);
      check("mrst_first_cmd", trig_cmd, STOP);
      check("mrst_first_src", trig_src, 0);
      wait_not_busy(150, ok);
      check("mrst_first_done", ok, 1);
      tick(2);
      check("mrst_first_frames", frames_sent, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
